mul_signed_seq: RTL and testbench
=================================

// Module: mul_signed_seq
// PURPOSE
//  Issue/retire stage directly upstream and downstream of the 32-bit shift-add unsigned multiplier.
//  Accepts an operand pair and a signed/unsigned flag on a valid/ready handshake.
//  Converts signed operands to magnitudes and drives the multiplier's enable, operands and ready.
//  Captures the 64-bit product, restores the sign, and presents it with a tag to writeback on a valid/ready handshake.
// PARAMETERS
//  N      32  operand width; product is 2N bits
//  TAG_W  4   width of opaque tag carried from input to output
// PORTS
//  clk                input   1      clock
//  reset              input   1      synchronous, active-high reset
//  in_valid           input   1      operand pair valid
//  in_ready           output  1      block can accept operands
//  in_a               input   N      multiplier operand
//  in_b               input   N      multiplicand operand
//  in_signed          input   1      1: two's-complement operands; 0: unsigned
//  in_tag             input   TAG_W  tag, returned unchanged with the result
//  mul_enable         output  1      enable to multiplier
//  mul_multiplier     output  N      |a| (or a when unsigned), registered
//  mul_multiplicand   output  N      |b| (or b when unsigned), registered
//  mul_ready          input   1      multiplier done (registered in multiplier)
//  mul_product_upper  input   N      multiplier product [2N-1:N]
//  mul_product_lower  input   N      multiplier product [N-1:0]
//  out_valid          output  1      result valid
//  out_ready          input   1      writeback accepts result
//  out_hi             output  N      signed/unsigned product [2N-1:N]
//  out_lo             output  N      product [N-1:0]
//  out_tag            output  TAG_W  tag of this result
// BEHAVIOUR
//  - Reset is shared with the multiplier.
//  - Reset values: state=IDLE; in_ready=1; out_valid=0; mul_enable=0; all data/tag regs=0.
//  - Reset mid-operation: abandon the operation, return to IDLE; no result is emitted.
//  - FSM states:
//    IDLE: in_ready=1. On in_valid → LOAD.
//          On that edge, register the magnitudes, the negate flag and the tag.
//          Magnitude = two's-complement negate when in_signed and the MSB is 1.
//          -2^(N-1) → 2^(N-1), which fits unsigned.
//          neg = in_signed & (a[N-1] ^ b[N-1]).
//    LOAD: mul_enable=1 for exactly 1 cycle (multiplier samples operands, clears its ready) → RUN.
//    RUN: mul_enable = ~mul_ready (combinational), so the multiplier never re-starts after completion.
//         mul_ready is ignored in LOAD; a stale ready from the previous op must not end RUN.
//         On mul_ready=1 → DONE; capture {upper,lower}, two's-complement negated over 2N bits when neg.
//    DONE: out_valid=1, outputs held stable. On out_ready → IDLE.
//          in_ready is 0 here; the next operand is accepted one cycle after the handshake.
//  - Latency (N=32): out_valid rises 36 cycles after the accepting in_valid&in_ready edge.
//  - out_valid is never asserted while in_ready=1. in_* inputs are ignored when in_ready=0.
//  - Arithmetic: unsigned result = full 2N-bit product.
//    Signed result = exact 2N-bit two's-complement product.
//    (-2^(N-1))*(-2^(N-1)) = 2^(2N-2), which is representable.
// CONFIGURATION
//  MUL_SEQ_ZERO_BYPASS_EN defined:
//    - In IDLE, if in_a==0 or in_b==0, go directly to DONE with result 0 and the tag.
//    - mul_enable stays 0; out_valid rises 1 cycle after accept.
//  Undefined: every operation goes through LOAD/RUN, including zero operands.
// TESTING
//  1. reset held 3 cycles mid-RUN → IDLE, in_ready=1, out_valid=0, mul_enable=0; next op correct.
//  2. Unsigned 0xFFFFFFFF*0xFFFFFFFF, tag 5 → out_hi=0xFFFFFFFE, out_lo=0x00000001, tag 5, 36 cycles.
//  3. Signed -3*7 → out_hi=0xFFFFFFFF, out_lo=0xFFFFFFEB.
//     Signed 0x80000000*0x80000000 → out_hi=0x40000000, out_lo=0.
//  4. out_ready low 10 cycles in DONE → outputs stable, in_ready=0, mul_enable=0.
//     Then out_ready=1 → in_ready=1 the next cycle.
//  5. Back-to-back ops with in_valid held high → each result correct.
//     Stale mul_ready at LOAD does not shorten RUN.
//  6. Zero operand (0*0x1234): with MUL_SEQ_ZERO_BYPASS_EN, result 0 after 1 cycle and mul_enable never 1.
//     Without the macro, result 0 after 36 cycles.

Source files
------------

// File: rtl/mul_signed_seq.sv
// mul_signed_seq
//   Issue/retire wrapper around an external N-bit shift-add unsigned
//   multiplier. Takes an operand pair plus a signed/unsigned flag, hands
//   the operand magnitudes to the multiplier, then restores the sign of the
//   2N-bit product and returns it with the caller's tag.
//
// Ports
//   clk, reset                         clock, synchronous active-high reset
//   in_valid/in_ready                  operand handshake
//   in_a, in_b, in_signed, in_tag      operands, signedness, opaque tag
//   mul_enable                         start/hold enable to the multiplier
//   mul_multiplier, mul_multiplicand   registered operand magnitudes
//   mul_ready                          multiplier done (registered there)
//   mul_product_upper/lower            raw unsigned product halves
//   out_valid/out_ready                result handshake
//   out_hi, out_lo, out_tag            signed-corrected product and tag
//
// Configuration
//   MUL_SEQ_ZERO_BYPASS_EN  when defined, a zero operand skips the
//                           multiplier and retires a zero result from IDLE.
module mul_signed_seq #(
  parameter int N     = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_signed,
  input  logic [TAG_W-1:0] in_tag,
  output logic             mul_enable,
  output logic [N-1:0]     mul_multiplier,
  output logic [N-1:0]     mul_multiplicand,
  input  logic             mul_ready,
  input  logic [N-1:0]     mul_product_upper,
  input  logic [N-1:0]     mul_product_lower,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_hi,
  output logic [N-1:0]     out_lo,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state_q;
  logic             in_ready_q, out_valid_q, neg_q;
  logic [N-1:0]     mul_a_q, mul_b_q, out_hi_q, out_lo_q;
  logic [TAG_W-1:0] tag_q;

  logic [N-1:0]     a_mag_d, b_mag_d;
  logic             neg_d;
  logic [2*N-1:0]   raw_d, prod_d;

  // Magnitudes: negating the most negative value wraps to 2^(N-1), which
  // is exactly right when read as unsigned by the multiplier.
  assign a_mag_d = (in_signed && in_a[N-1]) ? -in_a : in_a;
  assign b_mag_d = (in_signed && in_b[N-1]) ? -in_b : in_b;
  assign neg_d   = in_signed & (in_a[N-1] ^ in_b[N-1]);

  assign raw_d   = {mul_product_upper, mul_product_lower};
  assign prod_d  = neg_q ? -raw_d : raw_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      neg_q       <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      out_hi_q    <= '0;
      out_lo_q    <= '0;
      tag_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mul_a_q    <= a_mag_d;
            mul_b_q    <= b_mag_d;
            neg_q      <= neg_d;
            tag_q      <= in_tag;
            in_ready_q <= 1'b0;
`ifdef MUL_SEQ_ZERO_BYPASS_EN
            if (in_a == '0 || in_b == '0) begin
              out_hi_q    <= '0;
              out_lo_q    <= '0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= LOAD;
            end
`else
            state_q <= LOAD;
`endif
          end
        end
        // One-cycle start pulse; mul_ready here may still be the previous
        // op's done flag, so it is deliberately not looked at.
        LOAD: state_q <= RUN;
        RUN: begin
          if (mul_ready) begin
            {out_hi_q, out_lo_q} <= prod_d;
            out_valid_q          <= 1'b1;
            state_q              <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Enable drops as soon as the multiplier reports done so it cannot
  // restart on the same operands while we sit in RUN for the capture edge.
  assign mul_enable       = (state_q == LOAD) || ((state_q == RUN) && !mul_ready);
  assign in_ready         = in_ready_q;
  assign out_valid        = out_valid_q;
  assign mul_multiplier   = mul_a_q;
  assign mul_multiplicand = mul_b_q;
  assign out_hi           = out_hi_q;
  assign out_lo           = out_lo_q;
  assign out_tag          = tag_q;

endmodule

// File: tb/tb_mul_signed_seq.sv
// Testbench for mul_signed_seq: models the external shift-add multiplier
// (34 edges from operand sample to done, done held until the next start)
// and checks results against plain signed/unsigned 64-bit arithmetic.
module tb_mul_signed_seq;
  localparam int N  = 32;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, in_signed;
  logic [N-1:0]  in_a, in_b;
  logic [TW-1:0] in_tag;
  logic          mul_enable, mul_ready;
  logic [N-1:0]  mul_multiplier, mul_multiplicand;
  logic [N-1:0]  mul_product_upper, mul_product_lower;
  logic          out_valid, out_ready;
  logic [N-1:0]  out_hi, out_lo;
  logic [TW-1:0] out_tag;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;

  always #5 clk = ~clk;

  mul_signed_seq #(.N(N), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .in_tag(in_tag),
    .mul_enable(mul_enable), .mul_multiplier(mul_multiplier),
    .mul_multiplicand(mul_multiplicand), .mul_ready(mul_ready),
    .mul_product_upper(mul_product_upper), .mul_product_lower(mul_product_lower),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_hi(out_hi), .out_lo(out_lo), .out_tag(out_tag)
  );

  // External multiplier model: starts when enabled while idle, busy for
  // 34 edges, then raises done and keeps it until the next start.
  logic [N-1:0]   m_a, m_b;
  logic [2*N-1:0] m_prod;
  int             m_cnt;
  always @(posedge clk) begin
    if (reset) begin
      m_cnt     <= 0;
      mul_ready <= 1'b1;
      m_prod    <= '0;
    end else if (m_cnt == 0) begin
      if (mul_enable) begin
        m_a       <= mul_multiplier;
        m_b       <= mul_multiplicand;
        m_cnt     <= 34;
        mul_ready <= 1'b0;
      end
    end else begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        mul_ready <= 1'b1;
        m_prod    <= {32'b0, m_a} * {32'b0, m_b};
      end
    end
  end
  assign mul_product_upper = m_prod[2*N-1:N];
  assign mul_product_lower = m_prod[N-1:0];

  always @(posedge clk) if (mul_enable) en_cnt <= en_cnt + 1;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, b, input logic sgn);
    logic signed [63:0] sa, sb;
    if (sgn) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after a posedge with the DUT idle.
  task automatic do_op(input logic [31:0] a, b, input logic sgn,
                       input logic [3:0] tag, input int hold);
    logic [63:0] exp;
    int lat, exp_lat, en0;
    exp     = ref_mul(a, b, sgn);
    exp_lat = 36;
`ifdef MUL_SEQ_ZERO_BYPASS_EN
    if (a == 0 || b == 0) exp_lat = 0;  // result visible right after accept
`endif
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1; in_a = a; in_b = b; in_signed = sgn; in_tag = tag;
    out_ready = 0;
    en0 = en_cnt;
    @(posedge clk); #1;
    // Garbage while busy must be ignored.
    in_a = $urandom; in_b = $urandom; in_signed = 1'($urandom); in_tag = 4'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("out_hi", out_hi, exp[63:32]);
    chk("out_lo", out_lo, exp[31:0]);
    chk("out_tag", out_tag, tag);
    chk("in_ready_done", in_ready, 0);
    chk("mul_enable_done", mul_enable, 0);
    chk("enable_cycles", en_cnt - en0, (exp_lat == 0) ? 0 : 35);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_hi", out_hi, exp[63:32]);
      chk("hold_lo", out_lo, exp[31:0]);
      chk("hold_tag", out_tag, tag);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_enable", mul_enable, 0);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    in_valid  = 0;
    chk("in_ready_after", in_ready, 1);
    chk("out_valid_after", out_valid, 0);
  endtask

  initial begin
    int seen;
    reset = 1; in_valid = 0; in_a = 0; in_b = 0; in_signed = 0; in_tag = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_enable", mul_enable, 0);
    chk("rst_out", {out_hi, out_lo}, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_mul_ops", {mul_multiplier, mul_multiplicand}, 0);
    reset = 0;
    @(posedge clk); #1;

    // Reset in the middle of RUN abandons the op.
    in_valid = 1; in_a = 32'd1000; in_b = 32'd77; in_signed = 0; in_tag = 4'd9;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_enable", mul_enable, 0);
    reset = 0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid || mul_enable) seen++;
    end
    chk("midrst_no_result", seen, 0);

    do_op(32'd1234, 32'd5678, 1'b0, 4'd3, 0);
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'd5, 0);
    do_op(-32'sd3, 32'd7, 1'b1, 4'd1, 0);
    do_op(32'h80000000, 32'h80000000, 1'b1, 4'd2, 0);
    do_op(32'h80000000, 32'h7FFFFFFF, 1'b1, 4'd4, 0);
    do_op(32'hDEADBEEF, 32'h12345678, 1'b1, 4'd6, 10);
    do_op(32'd0, 32'h1234, 1'b0, 4'd7, 0);
    do_op(32'hFFFFFFF0, 32'd0, 1'b1, 4'd8, 2);
    // Back-to-back: in_valid stays high across handshakes; each start sees a
    // stale done from the previous op during LOAD.
    for (int i = 0; i < 10; i++)
      do_op($urandom, $urandom, 1'($urandom), 4'($urandom), int'($urandom_range(0, 3)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
